// File: rtl/alu_mdu_n_if.sv
// Request/response bundle for alu_mdu_n: operand handshake in, result handshake out.
// The master side issues operands and consumes results; the slave side is the ALU.
interface alu_mdu_n_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         o_ready;
  logic [3:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] result;
  logic         overflow;
  logic         zero;
  logic         equal;
  logic         div_by_zero;

  modport master (
    output i_valid, op, a, b, i_ready,
    input  o_ready, o_valid, result, overflow, zero, equal, div_by_zero
  );

  modport slave (
    input  i_valid, op, a, b, i_ready,
    output o_ready, o_valid, result, overflow, zero, equal, div_by_zero
  );
endinterface

// File: rtl/alu_mdu_n.sv
// N-bit sequential ALU: single-cycle logic/shift/add ops plus iterative
// radix-2 unsigned multiply and restoring divide (N+1 edges each).
module alu_mdu_n #(
  parameter int N       = 32,
  parameter int SHAMT_W = $clog2(N)
) (
  input logic         clk,
  input logic         rst,
  alu_mdu_n_if.slave  bus
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_SLL   = 4'd3;
  localparam logic [3:0] OP_SRL   = 4'd4;
  localparam logic [3:0] OP_SRA   = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t             state;
  logic [SHAMT_W-1:0] cnt;

  // Iterative working registers: hi/lo hold the partial product or the
  // remainder/quotient pair; bb is the multiplicand or divisor.
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [N-1:0] bb;
  logic         it_div;
  logic         it_hi;
  logic         eq_r;
  logic         bz_r;

  logic accept;
  logic is_iter;
  logic is_div;

  assign bus.o_ready = !rst && ((state == IDLE) || (state == DONE && bus.i_ready));
  assign accept      = bus.i_valid && bus.o_ready;
  assign is_iter     = (bus.op >= OP_MUL) && (bus.op <= OP_REMU);
  assign is_div      = (bus.op == OP_DIVU) || (bus.op == OP_REMU);

  // Shared adder: SUB/SLT/SLTU invert b and carry in one.
  logic                sub_mode;
  logic [N-1:0]        b_eff;
  logic [N:0]          add_full;
  logic [N-1:0]        sum;
  logic                cout;
  logic                add_ovf;
  logic signed [N-1:0] a_s;
  logic [SHAMT_W-1:0]  shamt;
  logic                big_shift;

  assign sub_mode  = (bus.op == OP_SUB) || (bus.op == OP_SLT) || (bus.op == OP_SLTU);
  assign b_eff     = sub_mode ? ~bus.b : bus.b;
  assign add_full  = {1'b0, bus.a} + {1'b0, b_eff} + (N+1)'(sub_mode);
  assign sum       = add_full[N-1:0];
  assign cout      = add_full[N];
  assign add_ovf   = (bus.a[N-1] == b_eff[N-1]) && (sum[N-1] != bus.a[N-1]);
  assign a_s       = bus.a;
  assign shamt     = bus.b[SHAMT_W-1:0];
  assign big_shift = |bus.b[N-1:SHAMT_W];

  logic [N-1:0] s_res;
  logic         s_ovf;

  always_comb begin
    s_res = '0;
    s_ovf = 1'b0;
    case (bus.op)
      OP_AND:  s_res = bus.a & bus.b;
      OP_OR:   s_res = bus.a | bus.b;
      OP_XOR:  s_res = bus.a ^ bus.b;
      OP_SLL:  s_res = big_shift ? '0 : (bus.a << shamt);
      OP_SRL:  s_res = big_shift ? '0 : (bus.a >> shamt);
      OP_SRA:  s_res = big_shift ? '0 : N'(a_s >>> shamt);
      OP_ADD,
      OP_SUB: begin
        s_res = sum;
        s_ovf = add_ovf;
      end
      OP_SLT: begin
        s_res = {{(N-1){1'b0}}, add_ovf ^ sum[N-1]};
        s_ovf = add_ovf;
      end
      OP_SLTU: s_res = {{(N-1){1'b0}}, ~cout};
      default: s_res = '0;
    endcase
  end

  // One radix-2 step: shift-add for multiply, shift-subtract for divide.
  logic [N:0]   madd;
  logic [N:0]   dsh;
  logic [N+1:0] ddiff;
  logic         take;
  logic [N-1:0] nx_hi;
  logic [N-1:0] nx_lo;
  logic [N-1:0] f_res;
  logic         f_ovf;

  assign madd  = {1'b0, hi} + (lo[0] ? {1'b0, bb} : {(N+1){1'b0}});
  assign dsh   = {hi, lo[N-1]};
  assign ddiff = {1'b0, dsh} - {2'b00, bb};
  assign take  = !ddiff[N+1];

  always_comb begin
    if (it_div) begin
      nx_hi = take ? ddiff[N-1:0] : dsh[N-1:0];
      nx_lo = {lo[N-2:0], take};
    end else begin
      nx_hi = madd[N:1];
      nx_lo = {madd[0], lo[N-1:1]};
    end
  end

  assign f_res = it_hi ? nx_hi : nx_lo;
  assign f_ovf = !it_div && (nx_hi != '0);

  // Working registers carry no reset; they are loaded on every accept.
  always_ff @(posedge clk) begin
    if (accept && is_iter) begin
      hi     <= '0;
      lo     <= is_div ? bus.a : bus.b;
      bb     <= is_div ? bus.b : bus.a;
      it_div <= is_div;
      it_hi  <= (bus.op == OP_MULHU) || (bus.op == OP_REMU);
      eq_r   <= (bus.a == bus.b);
      bz_r   <= is_div && (bus.b == '0);
    end else if (state == ITER) begin
      hi <= nx_hi;
      lo <= nx_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.o_valid     <= 1'b0;
      bus.result      <= '0;
      bus.overflow    <= 1'b0;
      bus.zero        <= 1'b0;
      bus.equal       <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_iter) begin
              state       <= ITER;
              cnt         <= '0;
              bus.o_valid <= 1'b0;
            end else begin
              state           <= DONE;
              bus.o_valid     <= 1'b1;
              bus.result      <= s_res;
              bus.overflow    <= s_ovf;
              bus.zero        <= (s_res == '0);
              bus.equal       <= (bus.a == bus.b);
              bus.div_by_zero <= 1'b0;
            end
          end else if (state == DONE && bus.i_ready) begin
            state       <= IDLE;
            bus.o_valid <= 1'b0;
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == SHAMT_W'(N-1)) begin
            state           <= DONE;
            bus.o_valid     <= 1'b1;
            bus.result      <= f_res;
            bus.overflow    <= f_ovf;
            bus.zero        <= (f_res == '0);
            bus.equal       <= eq_r;
            bus.div_by_zero <= bz_r;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_n.sv
// Bench for alu_mdu_n (N=32): directed vector table, backpressure and reset
// sequences, then random operations against an arithmetic reference model.
module tb_alu_mdu_n;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_mdu_n_if #(.N(N)) bus ();

  alu_mdu_n #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        eq;
    logic        dbz;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        eq;
    logic        dbz;
    int          lat;
    logic        ready_in_iter;
  } obs_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic sovf(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'(a) * 64'(b);
    e.res = 32'd0;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = a ^ b;
      4'd3:  e.res = (b > 32'd31) ? 32'd0 : a << b;
      4'd4:  e.res = (b > 32'd31) ? 32'd0 : a >> b;
      4'd5:  e.res = (b > 32'd31) ? 32'd0 : 32'($signed(a) >>> b);
      4'd6:  begin e.res = a + b; e.ovf = sovf(sa + sb); end
      4'd7:  begin e.res = a - b; e.ovf = sovf(sa - sb); end
      4'd8:  begin e.res = (sa < sb) ? 32'd1 : 32'd0; e.ovf = sovf(sa - sb); end
      4'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin e.res = p[31:0];  e.ovf = (p[63:32] != 0); end
      4'd11: begin e.res = p[63:32]; e.ovf = (p[63:32] != 0); end
      4'd12: begin e.res = (b == 0) ? 32'hFFFF_FFFF : a / b; e.dbz = (b == 0); end
      4'd13: begin e.res = (b == 0) ? a : a % b;             e.dbz = (b == 0); end
      default: e.res = 32'd0;
    endcase
    e.zero = (e.res == 0);
    e.eq   = (a == b);
    return e;
  endfunction

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output obs_t o);
    int w;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    w = 0;
    while (!bus.o_ready && w < 100) begin @(negedge clk); w++; end
    if (!bus.o_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.op = 4'($urandom); bus.a = $urandom; bus.b = $urandom;
    o.lat = 1;
    o.ready_in_iter = 1'b0;
    while (!bus.o_valid && o.lat < 100) begin
      if (bus.o_ready) o.ready_in_iter = 1'b1;
      @(negedge clk);
      o.lat++;
    end
    o.res  = bus.result;
    o.ovf  = bus.overflow;
    o.zero = bus.zero;
    o.eq   = bus.equal;
    o.dbz  = bus.div_by_zero;
  endtask

  task automatic check_obs(input string tag, input logic [3:0] op, input exp_t e, input obs_t o);
    int exp_lat;
    exp_lat = (op >= 4'd10 && op <= 4'd13) ? N + 1 : 1;
    chk({tag, ".latency"}, 64'(o.lat), 64'(exp_lat));
    chk({tag, ".result"}, 64'(o.res), 64'(e.res));
    chk({tag, ".overflow"}, 64'(o.ovf), 64'(e.ovf));
    chk({tag, ".zero"}, 64'(o.zero), 64'(e.zero));
    chk({tag, ".equal"}, 64'(o.eq), 64'(e.eq));
    chk({tag, ".div_by_zero"}, 64'(o.dbz), 64'(e.dbz));
    if (exp_lat > 1) chk({tag, ".ready_in_iter"}, 64'(o.ready_in_iter), 64'(0));
  endtask

  vec_t vt[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t        o;
    exp_t        e;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        stable;
    int          vseen;

    //             op     a              b              res           ovf   zero  eq    dbz
    vt[0]  = '{4'd6,  32'h7FFF_FFFF, 32'h1,         '{32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vt[1]  = '{4'd3,  32'h1,         32'd32,        '{32'h0,         1'b0, 1'b1, 1'b0, 1'b0}};
    vt[2]  = '{4'd5,  32'h8000_0000, 32'd4,         '{32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[3]  = '{4'd10, 32'hFFFF_FFFF, 32'd2,         '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0}};
    vt[4]  = '{4'd11, 32'hFFFF_FFFF, 32'd2,         '{32'h1,         1'b1, 1'b0, 1'b0, 1'b0}};
    vt[5]  = '{4'd12, 32'd100,       32'd7,         '{32'd14,        1'b0, 1'b0, 1'b0, 1'b0}};
    vt[6]  = '{4'd13, 32'd100,       32'd7,         '{32'd2,         1'b0, 1'b0, 1'b0, 1'b0}};
    vt[7]  = '{4'd12, 32'd100,       32'd0,         '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
    vt[8]  = '{4'd13, 32'd100,       32'd0,         '{32'd100,       1'b0, 1'b0, 1'b0, 1'b1}};
    vt[9]  = '{4'd7,  32'd5,         32'd5,         '{32'h0,         1'b0, 1'b1, 1'b1, 1'b0}};
    vt[10] = '{4'd8,  32'hFFFF_FFFF, 32'd1,         '{32'h1,         1'b0, 1'b0, 1'b0, 1'b0}};
    vt[11] = '{4'd9,  32'hFFFF_FFFF, 32'd1,         '{32'h0,         1'b0, 1'b1, 1'b0, 1'b0}};
    vt[12] = '{4'd14, 32'd3,         32'd3,         '{32'h0,         1'b0, 1'b1, 1'b1, 1'b0}};
    vt[13] = '{4'd7,  32'h8000_0000, 32'd1,         '{32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0}};
    vt[14] = '{4'd4,  32'h8000_0000, 32'd31,        '{32'h1,         1'b0, 1'b0, 1'b0, 1'b0}};
    vt[15] = '{4'd2,  32'h0000_F0F0, 32'h0000_00FF, '{32'h0000_F00F, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[16] = '{4'd8,  32'h8000_0000, 32'd1,         '{32'h1,         1'b1, 1'b0, 1'b0, 1'b0}};
    vt[17] = '{4'd5,  32'h8000_0000, 32'h100,       '{32'h0,         1'b0, 1'b1, 1'b0, 1'b0}};

    bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.op = 4'd0; bus.a = '0; bus.b = '0;
    #12;
    chk("reset.o_ready", 64'(bus.o_ready), 0);
    chk("reset.o_valid", 64'(bus.o_valid), 0);
    chk("reset.result", 64'(bus.result), 0);
    chk("reset.zero", 64'(bus.zero), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      run(vt[i].op, vt[i].a, vt[i].b, o);
      check_obs($sformatf("vec%0d", i), vt[i].op, vt[i].e, o);
    end

    // Backpressure in DONE, then accept on the consuming edge
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.op = 4'd6; bus.a = 32'h7FFF_FFFF; bus.b = 32'h1; bus.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("bp.o_valid", 64'(bus.o_valid), 1);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (!(bus.o_valid && !bus.o_ready && bus.result == 32'h8000_0000 &&
            bus.overflow && !bus.zero && !bus.equal)) stable = 1'b0;
    end
    chk("bp.stable", 64'(stable), 1);
    bus.i_ready = 1'b1; bus.i_valid = 1'b1;
    bus.op = 4'd7; bus.a = 32'd5; bus.b = 32'd5;
    #1;
    chk("bp.o_ready", 64'(bus.o_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("bp2.o_valid", 64'(bus.o_valid), 1);
    chk("bp2.result", 64'(bus.result), 0);
    chk("bp2.zero", 64'(bus.zero), 1);
    chk("bp2.equal", 64'(bus.equal), 1);

    // Async reset partway through a divide
    run(4'd6, 32'd2, 32'd2, o);
    chk("pre_rst.result", 64'(o.res), 4);
    @(negedge clk);
    bus.op = 4'd12; bus.a = 32'd1000; bus.b = 32'd3; bus.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst.result", 64'(bus.result), 0);
    chk("rst.o_valid", 64'(bus.o_valid), 0);
    chk("rst.o_ready", 64'(bus.o_ready), 0);
    chk("rst.equal", 64'(bus.equal), 0);
    @(negedge clk);
    rst = 1'b0;
    vseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) vseen++;
    end
    chk("rst.no_valid", 64'(vseen), 0);
    run(4'd6, 32'd2, 32'd3, o);
    check_obs("post_rst_add", 4'd6, model(4'd6, 32'd2, 32'd3), o);
    chk("post_rst_add.const", 64'(o.res), 5);

    // Random operations against the reference model
    for (int k = 0; k < 200; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'($urandom_range(0, 40));
        1:       rb = 32'd0;
        2:       rb = ra;
        default: rb = $urandom;
      endcase
      e = model(rop, ra, rb);
      run(rop, ra, rb, o);
      check_obs($sformatf("rand%0d_op%0d", k, rop), rop, e, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu_n.md
Name: alu_mdu_n

Overview:
- Parametrised N-bit sequential ALU with the existing ALU operation set plus iterative unsigned multiply and divide.
- Operands enter through a valid/ready handshake. Each result leaves with registered flags through a second valid/ready handshake.
- Sits between operand fetch and writeback. Simple ops finish in 1 cycle; MUL/DIV ops take N+1 cycles.

Parameters:
N, 32, datapath width; even, >= 8.
SHAMT_W, $clog2(N), derived shift-amount width; not overridden.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
i_valid  input  1  request valid.
o_ready  output  1  block can accept a request this cycle.
op  input  4  operation: 0 AND, 1 OR, 2 XOR, 3 SLL, 4 SRL, 5 SRA, 6 ADD, 7 SUB, 8 SLT, 9 SLTU, 10 MUL, 11 MULHU, 12 DIVU, 13 REMU, 14-15 reserved.
a  input  N  operand A.
b  input  N  operand B.
o_valid  output  1  result valid.
i_ready  input  1  consumer takes the result this cycle.
result  output  N  registered result.
overflow  output  1  registered overflow flag.
zero  output  1  registered flag: result == 0.
equal  output  1  registered flag: a == b of the accepted request.
div_by_zero  output  1  registered flag: DIVU/REMU issued with b == 0.

Behaviour:
- Reset (async, active-high): state IDLE; result, overflow, zero, equal, div_by_zero, o_valid = 0; o_ready = 0 while rst is high.
- A request is accepted on a rising edge with i_valid && o_ready; a, b and op are captured on that edge only.
- o_ready = (state == IDLE) || (state == DONE && i_ready). Back-to-back accept on the same edge as result consumption is allowed.
- States:
  - IDLE.
  - ITER: counter 0..N-1, one step per edge.
  - DONE: o_valid = 1.
- Transitions:
  - Accept of ops 0-9 or 14-15: compute and register result and flags on the accept edge, go to DONE. Latency 1 edge.
  - Accept of ops 10-13: load working registers, go to ITER with count 0.
  - ITER: one radix-2 step per edge. The step at count N-1 registers result and flags and goes to DONE. o_valid rises after N+1 edges including the accept edge.
  - DONE with i_ready: if i_valid, accept a new request; else go to IDLE.
  - DONE without i_ready: result, all flags and o_valid held stable.
- Arithmetic:
  - ADD/SUB/SLT share one N-bit adder: b is inverted and carry-in is 1 for SUB/SLT/SLTU.
  - overflow = signed overflow for ADD/SUB/SLT, else 0, except MUL/MULHU as below.
  - SLT = overflow ^ sum[N-1]. SLTU = ~carry_out. Both are zero-extended to N bits.
  - Shifts use b[SHAMT_W-1:0]. If any of b[N-1:SHAMT_W] is set, result = 0.
  - SRA sign-fills from a[N-1].
  - MUL: low N bits of the unsigned 2N-bit product. MULHU: high N bits. For both, overflow = (high N bits != 0).
  - DIVU: quotient. REMU: remainder. Restoring shift-subtract, MSB first.
  - Divide by zero: DIVU result = all ones, REMU result = a, div_by_zero = 1. Still takes N+1 edges.
  - div_by_zero = 0 for every other op.
  - Reserved ops: result = 0, all flags computed normally (zero = 1).
  - zero and equal are computed from the registered result and captured operands respectively.
- Input changes while in ITER or DONE have no effect.
- rst asserted mid-ITER or in DONE aborts the operation. No o_valid is produced; the block resumes in IDLE after reset release.
- Arithmetic is modulo 2^N throughout; no saturation.

Test Plan:
- ADD, N=32, a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow 1, zero 0, o_valid one edge after accept.
- SLL, a=1, b=32 -> result 0, zero 1. SRA, a=0x80000000, b=4 -> result 0xF8000000.
- MUL/MULHU, a=0xFFFFFFFF, b=2 -> MUL result 0xFFFFFFFE, MULHU result 1, overflow 1. o_valid after exactly 33 edges; o_ready 0 throughout ITER.
- DIVU/REMU, a=100, b=7 -> 14 and 2. With b=0 -> 0xFFFFFFFF and 100, div_by_zero 1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> result and flags stable, o_ready 0. Then i_ready=1 with i_valid=1 (SUB 5-5) -> new request accepted that edge; next result 0 with zero 1 and equal 1.
- Async rst pulse mid-DIVU at count 10 -> outputs 0 immediately, no o_valid. A following ADD 2+3 returns 5.
